// File: rtl/bus_hs_pkg.sv
// rtl/bus_hs_pkg.sv - shared state encoding and helpers for the valid/ready stages
// Used by backward_registered_v3 and its skid register.
package bus_hs_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PASS = 2'd1;
   localparam logic [1:0] ST_SKID = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      PASS = ST_PASS,
      SKID = ST_SKID
   } hs_state_e;

   // Number of bits needed to hold values 0..value-1.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >>> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/backward_registered_v3_if.sv
// rtl/backward_registered_v3_if.sv - valid/ready bus seen by the backward-registered stage
// master is the surrounding source/destination environment, slave is the stage itself.
interface backward_registered_v3_if #(
   parameter int WIDTH = 9
);

   logic             src_vaild;
   logic [WIDTH-1:0] src_data_in;
   logic             src_ready;
   logic             dst_ready;
   logic             dst_vaild;
   logic [WIDTH-1:0] dst_data_out;

   modport master (
      output src_vaild,
      output src_data_in,
      output dst_ready,
      input  src_ready,
      input  dst_vaild,
      input  dst_data_out
   );

   modport slave (
      input  src_vaild,
      input  src_data_in,
      input  dst_ready,
      output src_ready,
      output dst_vaild,
      output dst_data_out
   );

endinterface

// File: rtl/backward_registered_v3_skid_reg.sv
// rtl/backward_registered_v3_skid_reg.sv - one-entry skid register with valid bit
// load wins over drain; clr empties the entry and zeroes the data.
module skid_reg #(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic             drain,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             valid
);

   always_ff @(posedge clk) begin
      if (clr) begin
         q     <= '0;
         valid <= 1'b0;
      end else if (load) begin
         q     <= d;
         valid <= 1'b1;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/backward_registered_v3.sv
// rtl/backward_registered_v3.sv - ready-path registered pipeline stage with skid buffer
// src_ready comes straight from a flop; dst side is zero latency while the skid is empty.
module backward_registered_v3
   import bus_hs_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int DEPTH = 256
) (
   input  logic                      clk,
   input  logic                      s_rst,
   backward_registered_v3_if.slave   bus,
   output logic                      skid_full,
   output logic [clog2(DEPTH)-1:0]   xfer_cnt
);

   localparam int CNT_W = clog2(DEPTH);

   hs_state_e        state_q;
   hs_state_e        state_d;
   logic             src_ready_q;
   logic             skid_load;
   logic             skid_drain;
   logic [WIDTH-1:0] skid_data;
   logic             skid_valid;
   logic             dst_fire;

   skid_reg #(
      .WIDTH (WIDTH)
   ) u_skid (
      .clk   (clk),
      .clr   (s_rst),
      .load  (skid_load),
      .drain (skid_drain),
      .d     (bus.src_data_in),
      .q     (skid_data),
      .valid (skid_valid)
   );

   // src_ready is registered from the next state so dst_ready never reaches it combinationally.
   always_ff @(posedge clk) begin
      if (s_rst) begin
         state_q     <= IDLE;
         src_ready_q <= 1'b0;
         xfer_cnt    <= '0;
      end else begin
         state_q     <= state_d;
         src_ready_q <= (state_d == PASS);
         if (dst_fire) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d          = state_q;
      skid_load        = 1'b0;
      skid_drain       = 1'b0;
      bus.dst_vaild    = 1'b0;
      bus.dst_data_out = bus.src_data_in;
      case (state_q)
         IDLE: begin
            state_d = PASS;
         end
         PASS: begin
            bus.dst_vaild = bus.src_vaild;
            if (bus.src_vaild && !bus.dst_ready) begin
               skid_load = 1'b1;
               state_d   = SKID;
            end
         end
         SKID: begin
            bus.dst_vaild    = 1'b1;
            bus.dst_data_out = skid_data;
            if (bus.dst_ready) begin
               skid_drain = 1'b1;
               state_d    = PASS;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign dst_fire      = bus.dst_vaild && bus.dst_ready;
   assign bus.src_ready = src_ready_q;
   assign skid_full     = skid_valid;

endmodule

// File: doc/backward_registered_v3.md
Name: backward_registered_v3

Overview:
- Backward-registered (ready-path) pipeline stage for the valid/ready bus; the counterpart to the forward-registered stage.
- The forward stage registers valid/data. This stage instead registers the ready path back toward the source, using a one-entry skid buffer.
- Sits between source_v3 and destination_v3, or chained after a forward stage, to break long combinational ready chains.
- Also provides a modulo-DEPTH count of completed destination transfers, for bench scoreboarding.

Parameters:
- WIDTH, 9, data bus width in bits.
- DEPTH, 256, modulus of the transfer counter. Must be a power of two, >= 2.

Ports:
- clk  input  1  system clock; all flops are rising-edge.
- s_rst  input  1  reset; synchronous, active-high.
- src_vaild  input  1  source beat valid.
- src_data_in  input  WIDTH  source beat data.
- src_ready  output  1  stage can accept; driven directly by a flop.
- dst_ready  input  1  destination can accept.
- dst_vaild  output  1  beat valid toward destination.
- dst_data_out  output  WIDTH  beat data toward destination.
- skid_full  output  1  skid register holds a beat.
- xfer_cnt  output  $clog2(DEPTH)  count of dst handshakes, modulo DEPTH.

Behaviour:
- Handshakes:
  - Source handshake: src_vaild && src_ready at a rising edge.
  - Destination handshake: dst_vaild && dst_ready at a rising edge.
  - A beat is never dropped or duplicated; order is preserved.
- src_ready must be a flop output, with no combinational path from dst_ready. dst_vaild and dst_data_out may be combinational from src_* (zero latency in PASS).
- Reset values: src_ready=0, skid_full=0, xfer_cnt=0, dst_vaild=0. Skid data register is cleared to 0.
- FSM, 3 states:
  - IDLE (reset state):
    - src_ready=0, dst_vaild=0.
    - Moves to PASS on the first edge with s_rst=0.
    - src_ready rises one cycle after reset release.
  - PASS (skid empty):
    - src_ready=1, dst_vaild=src_vaild, dst_data_out=src_data_in.
    - If src_vaild && !dst_ready: capture src_data_in into skid, go to SKID, src_ready=0 next cycle.
    - Otherwise stay in PASS.
  - SKID (skid holds one beat):
    - src_ready=0, dst_vaild=1, dst_data_out=skid data, skid_full=1.
    - If dst_ready: go to PASS, src_ready=1 next cycle, skid_full=0.
    - src_vaild is ignored while in SKID. The source must hold its beat because src_ready=0.
- Boundary cases:
  - PASS, src_vaild=1, dst_ready=1: beat passes straight through in the same cycle; no skid use.
  - PASS, src_vaild=0: dst_vaild=0. dst_data_out is don't-care but follows src_data_in.
  - SKID drain: exactly one dst beat per cycle, so the throughput penalty is at most 1 bubble per stall.
  - xfer_cnt increments by 1 on every dst handshake and wraps DEPTH-1 -> 0. It is not affected by source-only handshakes.
  - Reset asserted mid-operation: next edge goes to IDLE, any skid beat is discarded, xfer_cnt=0. s_rst overrides all other events in the same cycle.
- Skid and FSM flops update only on clock edges; no latches.

Decomposition:
- Package bus_hs_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_PASS=2'd1, ST_SKID=2'd2.
  - Shared function clog2, for xfer_cnt width.
- One sub-module, skid_reg: WIDTH-bit load-enabled register plus valid bit, with synchronous clear.
- FSM and counter stay in the top module.

Test Plan:
- Reset release: s_rst=1 for 5 cycles, then 0 -> src_ready=0 during reset and on the release edge; src_ready=1 one cycle later. dst_vaild=0 and xfer_cnt=0 throughout.
- Pass-through: dst_ready=1, source sends 0x000..0x0FF back-to-back -> 256 beats arrive in order with zero latency. src_ready stays 1. xfer_cnt wraps to 0 after the 256th beat.
- Single stall: send 0x055 while dst_ready=0, then raise dst_ready 3 cycles later -> skid_full=1 and src_ready=0 for 3 cycles. dst_data_out=0x055 is held. 0x055 is delivered once, and src_ready returns to 1 the cycle after.
- Random backpressure: 300 cycles with random src_vaild (held while not accepted) and random dst_ready -> scoreboard shows no loss, duplication or reorder. xfer_cnt equals delivered count mod 256.
- Simultaneous events: in SKID with src_vaild=1 (data 0x1A3) and dst_ready=1 -> skid beat delivered first. 0x1A3 is accepted only after src_ready=1, then passes through.
- Reset mid-stall: in SKID holding 0x0F0, assert s_rst for 1 cycle -> next edge gives skid_full=0, dst_vaild=0, src_ready=0, xfer_cnt=0. 0x0F0 is never delivered.
